// File: rtl/irq_pending_ctrl.sv
// Interrupt front end: per-source edge/level pending tracking, fixed-priority
// arbitration (highest index wins) and a req/ack/done claim handshake to the core.

module priority_encoder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         i_en,
    input  logic [N-1:0] i_a,
    output logic [W-1:0] o_y,
    output logic         o_indicate
);
    // Ascending scan: the last set bit seen is the highest index, so it wins.
    always_comb begin
        o_y        = '0;
        o_indicate = 1'b0;
        if (i_en) begin
            for (int i = 0; i < N; i++) begin
                if (i_a[i]) begin
                    o_y        = W'(i);
                    o_indicate = 1'b1;
                end
            end
        end
    end
endmodule

module irq_pending_ctrl #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [N_SRC-1:0] edge_mode,
    input  logic [N_SRC-1:0] irq_enable,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    input  logic             irq_ack,
    input  logic             irq_done,
    output logic             busy,
    output logic [N_SRC-1:0] pending,
    output logic [1:0]       o_dbg_state
);
    // Handshake: irq_req stays high with a stable irq_id until the core pulses
    // irq_ack (claim) or the request is withdrawn because the source is no longer
    // eligible; after a claim, busy stays high until the core pulses irq_done.
    // irq_ack outside a request and irq_done outside service are ignored.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_irq_id;
    logic [ID_W-1:0]    w_irq_id_nxt;
    logic [N_SRC-1:0]   r_irq_q;
    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-1:0]   w_pending_nxt;
    logic [N_SRC-1:0]   w_rise;
    logic [N_SRC-1:0]   w_eligible;
    logic [N_SRC-1:0]   w_claim_mask;
    logic               w_claim;
    logic [ID_W-1:0]    w_enc_y;
    logic               w_enc_ind;

    assign w_rise       = irq_in & ~r_irq_q;
    assign w_eligible   = r_pending & irq_enable;
    assign w_claim      = (r_state == ST_REQ) && irq_ack;
    assign w_claim_mask = w_claim ? (N_SRC'(1) << r_irq_id) : '0;

    // A rise coincident with a claim keeps the bit set, so the new edge is not lost.
    assign w_pending_nxt = (edge_mode & (w_rise | (r_pending & ~w_claim_mask)))
                         | (~edge_mode & irq_in);

    priority_encoder #(
        .N (N_SRC),
        .W (ID_W)
    ) u_prio (
        .i_en       (r_state == ST_IDLE),
        .i_a        (w_eligible),
        .o_y        (w_enc_y),
        .o_indicate (w_enc_ind)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_irq_id_nxt = r_irq_id;
        case (r_state)
            ST_IDLE: begin
                if (w_enc_ind) begin
                    w_state_nxt  = ST_REQ;
                    w_irq_id_nxt = w_enc_y;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    w_state_nxt = ST_SERVICE;
                end else if (!w_eligible[r_irq_id]) begin
                    w_state_nxt  = ST_IDLE;
                    w_irq_id_nxt = '0;
                end
            end
            ST_SERVICE: begin
                if (irq_done) begin
                    w_state_nxt  = ST_IDLE;
                    w_irq_id_nxt = '0;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_irq_id_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_irq_id  <= '0;
            r_irq_q   <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_irq_id  <= w_irq_id_nxt;
            r_irq_q   <= irq_in;
            r_pending <= w_pending_nxt;
        end
    end

    assign irq_req     = (r_state == ST_REQ);
    assign busy        = (r_state == ST_SERVICE);
    assign irq_id      = r_irq_id;
    assign pending     = r_pending;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: directed vector table, hand-written corner sequences
// and a randomized run scored against a behavioural model.

module tb_irq_pending_ctrl;
    localparam int N = 8;
    localparam int W = 1 + 3 + 1 + N;

    logic       clk;
    logic       rst;
    logic [7:0] irq_in;
    logic [7:0] edge_mode;
    logic [7:0] irq_enable;
    logic       irq_ack;
    logic       irq_done;
    logic       irq_req;
    logic [2:0] irq_id;
    logic       busy;
    logic [7:0] pending;
    logic [1:0] dbg_state;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] exp_q[$];

    irq_pending_ctrl #(.N_SRC(8), .ID_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .edge_mode   (edge_mode),
        .irq_enable  (irq_enable),
        .irq_req     (irq_req),
        .irq_id      (irq_id),
        .irq_ack     (irq_ack),
        .irq_done    (irq_done),
        .busy        (busy),
        .pending     (pending),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // mode: 0 nothing outstanding, 1 offered to core, 2 in service
    logic [7:0] m_seen;
    logic [7:0] m_pend;
    int         m_mode;
    int         m_id;

    task automatic model_step();
        logic [7:0] elig;
        logic [7:0] np;
        int         best;
        if (rst) begin
            m_seen = '0;
            m_pend = '0;
            m_mode = 0;
            m_id   = 0;
        end else begin
            elig = m_pend & irq_enable;
            for (int i = 0; i < N; i++) begin
                if (edge_mode[i])
                    np[i] = (irq_in[i] && !m_seen[i]) ||
                            (m_pend[i] && !(m_mode == 1 && irq_ack && m_id == i));
                else
                    np[i] = irq_in[i];
            end
            if (m_mode == 0) begin
                best = -1;
                for (int i = N - 1; i >= 0; i--)
                    if (elig[i] && best < 0) best = i;
                if (best >= 0) begin
                    m_mode = 1;
                    m_id   = best;
                end
            end else if (m_mode == 1) begin
                if (irq_ack) m_mode = 2;
                else if (!elig[m_id]) begin
                    m_mode = 0;
                    m_id   = 0;
                end
            end else if (irq_done) begin
                m_mode = 0;
                m_id   = 0;
            end
            m_seen = irq_in;
            m_pend = np;
        end
    endtask

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic e_req, input logic [2:0] e_id,
                             input logic e_busy, input logic [7:0] e_pend);
        chk({name, ".req"},     32'(irq_req), 32'(e_req));
        chk({name, ".id"},      32'(irq_id),  32'(e_id));
        chk({name, ".busy"},    32'(busy),    32'(e_busy));
        chk({name, ".pending"}, 32'(pending), 32'(e_pend));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic step(input logic [7:0] irq_v, input logic ack_v, input logic done_v);
        irq_in   = irq_v;
        irq_ack  = ack_v;
        irq_done = done_v;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(8'h00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic [7:0] irq;
        logic [7:0] em;
        logic [7:0] en;
        logic       ack;
        logic       done;
        logic       e_req;
        logic [2:0] e_id;
        logic       e_busy;
        logic [7:0] e_pend;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [W-1:0] got;
        logic [W-1:0] exp;

        rst = 1'b1; irq_in = '0; edge_mode = 8'hFF; irq_enable = 8'hFF;
        irq_ack = 1'b0; irq_done = 1'b0;
        m_seen = '0; m_pend = '0; m_mode = 0; m_id = 0;

        // Priority between simultaneous edges, then level withdrawal on src 4.
        tbl[0]  = '{1'b1, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 8'h44, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h44};
        tbl[2]  = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 8'h44};
        tbl[3]  = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd6, 1'b1, 8'h04};
        tbl[4]  = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 8'h04};
        tbl[5]  = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h04};
        tbl[6]  = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h04};
        tbl[7]  = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 8'h00};
        tbl[8]  = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 8'h10, 8'hEF, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h10};
        tbl[10] = '{1'b0, 8'h10, 8'hEF, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h10};
        tbl[11] = '{1'b0, 8'h10, 8'hEF, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h10};
        tbl[12] = '{1'b0, 8'h00, 8'hEF, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00};
        tbl[13] = '{1'b0, 8'h00, 8'hEF, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};

        for (int i = 0; i < 14; i++) begin
            rst        = tbl[i].rst;
            edge_mode  = tbl[i].em;
            irq_enable = tbl[i].en;
            step(tbl[i].irq, tbl[i].ack, tbl[i].done);
            check_out($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_id,
                      tbl[i].e_busy, tbl[i].e_pend);
        end
        rst = 1'b0;

        // Reset while servicing src 5; a line high across reset release counts as a rise.
        edge_mode = 8'hFF; irq_enable = 8'hFF;
        do_reset();
        step(8'h20, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        check_out("rst_req5", 1'b1, 3'd5, 1'b0, 8'h20);
        step(8'h00, 1'b1, 1'b0);
        check_out("rst_svc5", 1'b0, 3'd5, 1'b1, 8'h00);
        rst = 1'b1;
        step(8'h08, 1'b0, 1'b0);
        check_out("rst_mid_svc", 1'b0, 3'd0, 1'b0, 8'h00);
        rst = 1'b0;
        step(8'h08, 1'b0, 1'b0);
        check_out("rst_release_rise", 1'b0, 3'd0, 1'b0, 8'h08);

        // No preemption: src 7 arrives while src 3 is requested.
        do_reset();
        step(8'h08, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        check_out("np_req3", 1'b1, 3'd3, 1'b0, 8'h08);
        step(8'h80, 1'b0, 1'b0);
        check_out("np_hold3", 1'b1, 3'd3, 1'b0, 8'h88);
        step(8'h00, 1'b0, 1'b0);
        check_out("np_hold3b", 1'b1, 3'd3, 1'b0, 8'h88);
        step(8'h00, 1'b1, 1'b0);
        check_out("np_svc3", 1'b0, 3'd3, 1'b1, 8'h80);
        step(8'h00, 1'b0, 1'b1);
        check_out("np_done3", 1'b0, 3'd0, 1'b0, 8'h80);
        step(8'h00, 1'b0, 1'b0);
        check_out("np_req7", 1'b1, 3'd7, 1'b0, 8'h80);

        // Edge re-trigger coincident with the claim of the same source.
        do_reset();
        step(8'h02, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        check_out("race_req1", 1'b1, 3'd1, 1'b0, 8'h02);
        step(8'h02, 1'b1, 1'b0);
        check_out("race_claim", 1'b0, 3'd1, 1'b1, 8'h02);
        step(8'h00, 1'b0, 1'b1);
        check_out("race_done", 1'b0, 3'd0, 1'b0, 8'h02);
        step(8'h00, 1'b0, 1'b0);
        check_out("race_req1_again", 1'b1, 3'd1, 1'b0, 8'h02);

        // Masking and ignored handshake strobes.
        do_reset();
        irq_enable = 8'hFE;
        step(8'h01, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        check_out("mask_hidden", 1'b0, 3'd0, 1'b0, 8'h01);
        step(8'h00, 1'b0, 1'b1);
        check_out("mask_spurious_done", 1'b0, 3'd0, 1'b0, 8'h01);
        irq_enable = 8'hFF;
        step(8'h00, 1'b0, 1'b0);
        check_out("mask_enabled_req", 1'b1, 3'd0, 1'b0, 8'h01);
        step(8'h00, 1'b1, 1'b0);
        check_out("mask_svc0", 1'b0, 3'd0, 1'b1, 8'h00);
        step(8'h00, 1'b1, 1'b0);
        check_out("mask_ack_in_svc", 1'b0, 3'd0, 1'b1, 8'h00);
        step(8'h00, 1'b0, 1'b1);
        check_out("mask_done0", 1'b0, 3'd0, 1'b0, 8'h00);

        // Randomized run scored against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) irq_in = 8'($urandom);
            if ($urandom_range(0, 31) == 0) edge_mode = 8'($urandom);
            if ($urandom_range(0, 15) == 0) irq_enable = 8'($urandom);
            irq_ack  = ($urandom_range(0, 1) == 0);
            irq_done = ($urandom_range(0, 2) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            @(posedge clk);
            model_step();
            exp_q.push_back({(m_mode == 1), 3'(m_id), (m_mode == 2), m_pend});
            #1;
            got = {irq_req, irq_id, busy, pending};
            exp = exp_q.pop_front();
            chk($sformatf("rand%0d", c), 32'(got), 32'(exp));
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
